// File: rtl/cpu_run_ctrl_if.sv
// Signal bundle between the AXI-Lite register block, the run controller and the core.
// The controller sits on the slave modport; the register block and core model sit on master.
interface cpu_run_ctrl_if;
  logic [31:0] cpu_ctrl;
  logic [31:0] axi_pc_write;
  logic        axi_pc_we;
  logic [31:0] core_pc;
  logic        core_retire;
  logic        core_ebreak;
  logic        core_en;
  logic        core_rst;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic [31:0] pc_read;
  logic [31:0] cpu_status;
  logic        cpu_running;
  logic        cpu_halted;
  logic [2:0]  cpu_state;

  modport slave (
    input  cpu_ctrl, axi_pc_write, axi_pc_we, core_pc, core_retire, core_ebreak,
    output core_en, core_rst, pc_load, pc_load_val, pc_read, cpu_status,
           cpu_running, cpu_halted, cpu_state
  );

  modport master (
    output cpu_ctrl, axi_pc_write, axi_pc_we, core_pc, core_retire, core_ebreak,
    input  core_en, core_rst, pc_load, pc_load_val, pc_read, cpu_status,
           cpu_running, cpu_halted, cpu_state
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step controller with breakpoint, single-step and EBREAK halting.
// Optional retire counter in status[31:16] when CPU_RUN_CTRL_RETIRE_CNT_EN is defined.
module cpu_run_ctrl #(
    parameter int BP_AW = 12
) (
    input logic          S_AXI_ACLK,
    input logic          S_AXI_ARESET,
    cpu_run_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam logic [2:0] CAUSE_NONE   = 3'd0;
    localparam logic [2:0] CAUSE_USER   = 3'd1;
    localparam logic [2:0] CAUSE_STEP   = 3'd2;
    localparam logic [2:0] CAUSE_BP     = 3'd3;
    localparam logic [2:0] CAUSE_EBREAK = 3'd4;

    state_t      state, state_nxt;
    logic [2:0]  cause, cause_nxt;
    logic        run_q, step_q, bp_skip, pc_drop;
    logic        pc_load_r;
    logic [31:0] pc_load_val_r;
    logic        run_rise, run_fall, step_rise, soft_rst, bp_en;
    logic        bp_match, bp_hit, retire_v, pc_ok, active, active_nxt, entering;
    logic        core_en_c;
    logic [15:0] retire_lo;
    logic        unused_ctrl_bits;

    assign unused_ctrl_bits = ^{bus.cpu_ctrl[31:16+BP_AW], bus.cpu_ctrl[15:4]};

    assign run_rise  = bus.cpu_ctrl[0] & ~run_q;
    assign run_fall  = ~bus.cpu_ctrl[0] & run_q;
    assign step_rise = bus.cpu_ctrl[1] & ~step_q;
    assign soft_rst  = bus.cpu_ctrl[2];
    assign bp_en     = bus.cpu_ctrl[3];

    assign bp_match = (bus.core_pc[BP_AW+1:2] == bus.cpu_ctrl[16+BP_AW-1:16]);
    assign bp_hit   = (state == ST_RUN) & bp_en & bp_match & ~bp_skip;
    assign retire_v = bus.core_retire & core_en_c;

    assign active     = (state == ST_RUN) || (state == ST_STEP);
    assign active_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
    assign entering   = active_nxt & ~active;
    assign pc_ok      = (state == ST_IDLE) || (state == ST_HALTED);

    // core_en is the only combinational control output: a breakpoint must stall the same cycle.
    always_comb begin
        core_en_c = 1'b0;
        case (state)
            ST_RUN:  core_en_c = ~bp_hit;
            ST_STEP: core_en_c = 1'b1;
            default: core_en_c = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = cause;
        if (soft_rst) begin
            state_nxt = ST_RESET;
        end else begin
            case (state)
                ST_RESET: state_nxt = ST_IDLE;
                ST_IDLE, ST_HALTED: begin
                    if (run_rise)       state_nxt = ST_RUN;
                    else if (step_rise) state_nxt = ST_STEP;
                    if ((state == ST_IDLE) && (run_rise || step_rise)) cause_nxt = CAUSE_NONE;
                end
                ST_RUN: begin
                    if (retire_v & bus.core_ebreak) begin
                        state_nxt = ST_HALTED; cause_nxt = CAUSE_EBREAK;
                    end else if (bp_hit) begin
                        state_nxt = ST_HALTED; cause_nxt = CAUSE_BP;
                    end else if (run_fall) begin
                        state_nxt = ST_HALTED; cause_nxt = CAUSE_USER;
                    end
                end
                ST_STEP: begin
                    if (retire_v & bus.core_ebreak) begin
                        state_nxt = ST_HALTED; cause_nxt = CAUSE_EBREAK;
                    end else if (run_fall) begin
                        state_nxt = ST_HALTED; cause_nxt = CAUSE_USER;
                    end else if (retire_v) begin
                        state_nxt = ST_HALTED; cause_nxt = CAUSE_STEP;
                    end
                end
                default: state_nxt = ST_RESET;
            endcase
        end
    end

    // axi_pc_we is a single-cycle strobe with no backpressure: it is taken when halted/idle
    // (pc_load pulses one cycle later) and otherwise dropped with pc_drop recording the loss.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state         <= ST_RESET;
            cause         <= CAUSE_NONE;
            run_q         <= 1'b0;
            step_q        <= 1'b0;
            bp_skip       <= 1'b0;
            pc_drop       <= 1'b0;
            pc_load_r     <= 1'b0;
            pc_load_val_r <= 32'd0;
        end else begin
            state     <= state_nxt;
            cause     <= cause_nxt;
            run_q     <= bus.cpu_ctrl[0];
            step_q    <= bus.cpu_ctrl[1];
            pc_load_r <= bus.axi_pc_we & pc_ok;
            if (bus.axi_pc_we & pc_ok) pc_load_val_r <= bus.axi_pc_write;
            // Resuming on a breakpoint address must let that instruction retire once.
            if (entering)      bp_skip <= bp_match;
            else if (retire_v) bp_skip <= 1'b0;
            if ((state == ST_IDLE) && entering)  pc_drop <= 1'b0;
            else if (bus.axi_pc_we & ~pc_ok)     pc_drop <= 1'b1;
        end
    end

`ifdef CPU_RUN_CTRL_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET)                retire_cnt <= 32'd0;
        else if (state_nxt == ST_RESET)  retire_cnt <= 32'd0;
        else if (retire_v)               retire_cnt <= retire_cnt + 32'd1;
    end
    assign retire_lo = retire_cnt[15:0];
`else
    assign retire_lo = 16'd0;
`endif

    assign bus.core_en     = core_en_c;
    assign bus.core_rst    = (state == ST_RESET);
    assign bus.pc_load     = pc_load_r;
    assign bus.pc_load_val = pc_load_val_r;
    assign bus.pc_read     = bus.core_pc;
    assign bus.cpu_state   = state;
    assign bus.cpu_running = active;
    assign bus.cpu_halted  = (state == ST_HALTED);
    assign bus.cpu_status  = {retire_lo, 7'd0, pc_drop, cause, (state == ST_HALTED), active, state};

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: single-cycle core model, pc_load scoreboard, one task per scenario.
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_run_ctrl_if bus();

  cpu_run_ctrl #(.BP_AW(12)) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .bus         (bus)
  );

`ifdef CPU_RUN_CTRL_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic        retire_on = 1'b1;
  logic        ebreak_on = 1'b0;
  int          n_ret = 0;
  logic [31:0] pc_model = 32'd0;

  // Single-cycle core: retires every enabled cycle, PC load takes priority.
  assign bus.core_pc     = pc_model;
  assign bus.core_retire = bus.core_en & retire_on;
  assign bus.core_ebreak = bus.core_retire & ebreak_on;

  always @(posedge clk) begin
    if (bus.pc_load) pc_model <= bus.pc_load_val;
    else if (bus.core_retire) pc_model <= pc_model + 32'd4;
    if (bus.core_retire) n_ret <= n_ret + 1;
  end

  // Scoreboard: every pc_load pulse must match the oldest accepted write.
  always @(negedge clk) begin
    if (bus.pc_load === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pc_load_unexpected: got pulse val=%h, required no pulse", bus.pc_load_val);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.pc_load_val !== mon_exp) begin
          errors++;
          $display("FAIL pc_load_val: got %h, required %h", bus.pc_load_val, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.cpu_ctrl = 32'd0; bus.axi_pc_we = 1'b0; bus.axi_pc_write = 32'd0;
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.cpu_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d, required 0", bus.cpu_state); end
    checks++; if (bus.core_rst !== 1'b1) begin errors++; $display("FAIL rst_core_rst: got %b, required 1", bus.core_rst); end
    checks++; if (bus.core_en !== 1'b0) begin errors++; $display("FAIL rst_core_en: got %b, required 0", bus.core_en); end
    checks++; if (bus.pc_load !== 1'b0) begin errors++; $display("FAIL rst_pc_load: got %b, required 0", bus.pc_load); end
    checks++; if (bus.pc_load_val !== 32'd0) begin errors++; $display("FAIL rst_pc_load_val: got %h, required 0", bus.pc_load_val); end
    checks++; if (bus.cpu_status !== 32'd0) begin errors++; $display("FAIL rst_status: got %h, required 0", bus.cpu_status); end
    checks++; if ({bus.cpu_running, bus.cpu_halted} !== 2'b00) begin errors++; $display("FAIL rst_run_halt: got %b, required 00", {bus.cpu_running, bus.cpu_halted}); end
    rst = 1'b0;
    tick();
    checks++; if (bus.cpu_state !== 3'd1) begin errors++; $display("FAIL idle_after_rst: got %0d, required 1", bus.cpu_state); end
    checks++; if (bus.core_rst !== 1'b0) begin errors++; $display("FAIL idle_core_rst: got %b, required 0", bus.core_rst); end
  endtask

  task automatic test_pc_write_idle();
    bus.axi_pc_write = 32'h40; bus.axi_pc_we = 1'b1; exp_q.push_back(32'h40);
    tick();
    bus.axi_pc_we = 1'b0;
    checks++; if (bus.pc_load !== 1'b1) begin errors++; $display("FAIL idle_pc_load: got %b, required 1", bus.pc_load); end
    checks++; if (bus.pc_load_val !== 32'h40) begin errors++; $display("FAIL idle_pc_load_val: got %h, required 40", bus.pc_load_val); end
    tick();
    checks++; if (bus.pc_load !== 1'b0) begin errors++; $display("FAIL idle_pc_load_width: got %b, required 0", bus.pc_load); end
    checks++; if (bus.pc_read !== 32'h40) begin errors++; $display("FAIL pc_read: got %h, required 40", bus.pc_read); end
  endtask

  task automatic test_run();
    bus.cpu_ctrl = 32'h1;
    tick(); tick();
    checks++; if (bus.cpu_state !== 3'd2) begin errors++; $display("FAIL run_state: got %0d, required 2", bus.cpu_state); end
    checks++; if (bus.core_en !== 1'b1) begin errors++; $display("FAIL run_core_en: got %b, required 1", bus.core_en); end
    checks++; if (bus.cpu_status[3] !== 1'b1) begin errors++; $display("FAIL run_status_running: got %b, required 1", bus.cpu_status[3]); end
    bus.axi_pc_write = 32'h80; bus.axi_pc_we = 1'b1;
    tick();
    bus.axi_pc_we = 1'b0;
    checks++; if (bus.pc_load !== 1'b0) begin errors++; $display("FAIL run_pc_dropped: got %b, required 0", bus.pc_load); end
    checks++; if (bus.cpu_status[8] !== 1'b1) begin errors++; $display("FAIL run_pc_drop_flag: got %b, required 1", bus.cpu_status[8]); end
    bus.cpu_ctrl = 32'h0;
    tick();
    checks++; if (bus.cpu_state !== 3'd4) begin errors++; $display("FAIL user_halt_state: got %0d, required 4", bus.cpu_state); end
    checks++; if (bus.cpu_status[7:5] !== 3'd1) begin errors++; $display("FAIL user_halt_cause: got %0d, required 1", bus.cpu_status[7:5]); end
  endtask

  task automatic test_breakpoint();
    bit seen = 1'b0;
    bus.axi_pc_write = 32'h0; bus.axi_pc_we = 1'b1; exp_q.push_back(32'h0);
    tick();
    bus.axi_pc_we = 1'b0;
    tick();
    bus.cpu_ctrl = 32'h000A_0008;
    tick();
    bus.cpu_ctrl = 32'h000A_0009;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.cpu_state === 3'd2 && bus.core_pc === 32'h28) begin
        seen = 1'b1;
        checks++; if (bus.core_en !== 1'b0) begin errors++; $display("FAIL bp_core_en: got %b, required 0", bus.core_en); end
      end
      if (bus.cpu_state === 3'd4) break;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_match_cycle: got none, required RUN at pc 28"); end
    checks++; if (bus.cpu_state !== 3'd4) begin errors++; $display("FAIL bp_halt_state: got %0d, required 4", bus.cpu_state); end
    checks++; if (bus.cpu_status[7:5] !== 3'd3) begin errors++; $display("FAIL bp_cause: got %0d, required 3", bus.cpu_status[7:5]); end
    checks++; if (bus.core_pc !== 32'h28) begin errors++; $display("FAIL bp_halt_pc: got %h, required 28", bus.core_pc); end
    // Resume from the breakpoint: the instruction at 0x28 must now retire.
    bus.cpu_ctrl = 32'h000A_0008;
    tick();
    bus.cpu_ctrl = 32'h000A_0009;
    tick();
    checks++; if (bus.core_en !== 1'b1) begin errors++; $display("FAIL bp_resume_en: got %b, required 1", bus.core_en); end
    tick();
    checks++; if (bus.core_pc !== 32'h2C) begin errors++; $display("FAIL bp_resume_pc: got %h, required 2c", bus.core_pc); end
    bus.cpu_ctrl = 32'h000A_0008;
    tick();
    checks++; if (bus.cpu_state !== 3'd4) begin errors++; $display("FAIL fall_halt_state: got %0d, required 4", bus.cpu_state); end
    checks++; if (bus.core_pc !== 32'h30) begin errors++; $display("FAIL fall_retire_counted: got %h, required 30", bus.core_pc); end
  endtask

  task automatic test_step();
    int ret0;
    logic [15:0] cnt0, cnt_exp;
    bus.cpu_ctrl = 32'h0;
    tick();
    ret0 = n_ret; cnt0 = bus.cpu_status[31:16];
    cnt_exp = CNT_EN ? cnt0 + 16'd1 : 16'd0;
    bus.cpu_ctrl = 32'h2;
    tick();
    checks++; if (bus.cpu_state !== 3'd3) begin errors++; $display("FAIL step_state: got %0d, required 3", bus.cpu_state); end
    for (int i = 0; i < 8; i++) begin
      if (bus.cpu_state === 3'd4) break;
      tick();
    end
    checks++; if (bus.cpu_state !== 3'd4) begin errors++; $display("FAIL step_halt_state: got %0d, required 4", bus.cpu_state); end
    checks++; if (n_ret - ret0 !== 1) begin errors++; $display("FAIL step_retires: got %0d, required 1", n_ret - ret0); end
    checks++; if (bus.cpu_status[7:5] !== 3'd2) begin errors++; $display("FAIL step_cause: got %0d, required 2", bus.cpu_status[7:5]); end
    checks++; if (bus.cpu_status[31:16] !== cnt_exp) begin errors++; $display("FAIL step_retire_cnt: got %0d, required %0d", bus.cpu_status[31:16], cnt_exp); end
    bus.cpu_ctrl = 32'h0;
    tick();
  endtask

  task automatic test_pc_write_random();
    logic [31:0] v;
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      v = $urandom;
      bus.axi_pc_write = v; bus.axi_pc_we = 1'b1; exp_q.push_back(v);
      tick();
      bus.axi_pc_we = 1'b0;
    end
    tick(); tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_pc_pending: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_ebreak_vs_user();
    bus.cpu_ctrl = 32'h1;
    tick();
    checks++; if (bus.cpu_state !== 3'd2) begin errors++; $display("FAIL eb_run_state: got %0d, required 2", bus.cpu_state); end
    bus.cpu_ctrl = 32'h0; ebreak_on = 1'b1;
    tick();
    ebreak_on = 1'b0;
    checks++; if (bus.cpu_state !== 3'd4) begin errors++; $display("FAIL eb_halt_state: got %0d, required 4", bus.cpu_state); end
    checks++; if (bus.cpu_status[7:5] !== 3'd4) begin errors++; $display("FAIL eb_cause: got %0d, required 4", bus.cpu_status[7:5]); end
  endtask

  task automatic test_soft_rst();
    bus.cpu_ctrl = 32'h1;
    tick();
    checks++; if (bus.cpu_state !== 3'd2) begin errors++; $display("FAIL srst_run_state: got %0d, required 2", bus.cpu_state); end
    bus.cpu_ctrl = 32'h5;
    tick();
    checks++; if (bus.cpu_state !== 3'd0) begin errors++; $display("FAIL srst_state: got %0d, required 0", bus.cpu_state); end
    checks++; if (bus.core_rst !== 1'b1) begin errors++; $display("FAIL srst_core_rst: got %b, required 1", bus.core_rst); end
    checks++; if (bus.core_en !== 1'b0) begin errors++; $display("FAIL srst_core_en: got %b, required 0", bus.core_en); end
    checks++; if (bus.cpu_status[31:16] !== 16'd0) begin errors++; $display("FAIL srst_cnt: got %0d, required 0", bus.cpu_status[31:16]); end
    bus.cpu_ctrl = 32'h4;
    tick();
    checks++; if (bus.cpu_state !== 3'd0) begin errors++; $display("FAIL srst_hold: got %0d, required 0", bus.cpu_state); end
    bus.cpu_ctrl = 32'h0;
    tick();
    checks++; if (bus.cpu_state !== 3'd1) begin errors++; $display("FAIL srst_idle: got %0d, required 1", bus.cpu_state); end
  endtask

  task automatic test_async_reset();
    bus.cpu_ctrl = 32'h1;
    tick();
    checks++; if (bus.cpu_state !== 3'd2) begin errors++; $display("FAIL ar_run_state: got %0d, required 2", bus.cpu_state); end
    checks++; if (bus.cpu_status[8:5] !== 4'd0) begin errors++; $display("FAIL ar_entry_clear: got %h, required 0", bus.cpu_status[8:5]); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.core_en !== 1'b0) begin errors++; $display("FAIL ar_core_en: got %b, required 0", bus.core_en); end
    checks++; if (bus.cpu_state !== 3'd0) begin errors++; $display("FAIL ar_state: got %0d, required 0", bus.cpu_state); end
    bus.cpu_ctrl = 32'h0;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.cpu_state !== 3'd1) begin errors++; $display("FAIL ar_idle: got %0d, required 1", bus.cpu_state); end
  endtask

  task automatic test_back_to_back();
    bus.cpu_ctrl = 32'h3;
    bus.axi_pc_write = 32'h100; bus.axi_pc_we = 1'b1; exp_q.push_back(32'h100);
    tick();
    bus.axi_pc_we = 1'b0;
    checks++; if (bus.cpu_state !== 3'd2) begin errors++; $display("FAIL b2b_run_wins: got %0d, required 2", bus.cpu_state); end
    checks++; if (bus.pc_load !== 1'b1) begin errors++; $display("FAIL b2b_pc_load: got %b, required 1", bus.pc_load); end
    tick();
    checks++; if (bus.pc_read !== 32'h100) begin errors++; $display("FAIL b2b_pc_read: got %h, required 100", bus.pc_read); end
    bus.cpu_ctrl = 32'h0;
    tick(); tick();
    checks++; if (bus.cpu_halted !== 1'b1) begin errors++; $display("FAIL b2b_halted: got %b, required 1", bus.cpu_halted); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_pending: got %0d left, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_pc_write_idle();
    test_run();
    test_breakpoint();
    test_step();
    test_pc_write_random();
    test_ebreak_vs_user();
    test_soft_rst();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
